// File: rtl/core_cmd_dispatcher_pkg.sv
// Shared definitions for the compute-core command dispatcher: dispatcher
// states, default widths and the {we1, we0} strobe encodings.
package core_cmd_dispatcher_pkg;

  localparam int CMD_W_DEF     = 35;
  localparam int DEPTH_DEF     = 8;
  localparam int TIMEOUT_W_DEF = 20;
  localparam int CNT_W_DEF     = 31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Strobe field is {command_we1, command_we0}
  localparam logic [1:0] STB_NONE  = 2'b00;
  localparam logic [1:0] STB_LATCH = 2'b01;
  localparam logic [1:0] STB_START = 2'b10;

  // Strobes the core should see while the dispatcher sits in a given state
  function automatic logic [1:0] strobe_for(input state_t st);
    logic [1:0] stb;
    stb = STB_NONE;
    case (st)
      ST_LOAD:  stb = STB_LATCH;
      ST_START: stb = STB_START;
      default:  stb = STB_NONE;
    endcase
    return stb;
  endfunction

endpackage

// File: rtl/core_cmd_dispatcher_fifo.sv
// Synchronous instruction queue: DEPTH entries of WIDTH bits, with a
// combinational head word and registered occupancy level.
module cmd_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/core_cmd_dispatcher.sv
// Queues host instructions and feeds them one at a time to the compute core,
// waiting for done_ins between issues, with a hang watchdog and a program
// cycle counter.
module core_cmd_dispatcher
  import core_cmd_dispatcher_pkg::*;
#(
  parameter int CMD_W     = CMD_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     cmd_valid,
  input  logic [CMD_W-1:0]         cmd_data,
  input  logic                     cmd_last,
  output logic                     cmd_ready,
  output logic [CMD_W-1:0]         command_in,
  output logic                     command_we0,
  output logic                     command_we1,
  input  logic                     done_ins,
  output logic                     busy,
  output logic                     all_done,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         cycle_count
);

  // Last WAIT cycle the watchdog tolerates is the one where it reads all-ones minus one
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  state_t               state_q;
  state_t               state_d;
  logic                 ready_en;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CMD_W:0]       head;
  logic                 cur_last;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 counting;
  logic                 finish_ok;
  logic                 finish_err;

  assign cmd_ready  = ready_en && !fifo_full && !clear;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_pop   = (state_d == ST_LOAD);
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign finish_ok  = (state_q == ST_WAIT) && done_ins && cur_last;
  assign finish_err = (state_q == ST_WAIT) && (state_d == ST_ERR);

  cmd_fifo #(
    .WIDTH (CMD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (fifo_push),
    .wdata ({cmd_last, cmd_data}),
    .pop   (fifo_pop),
    .rdata (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state logic; done_ins beats the watchdog and clear beats everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty && !timeout_err && !all_done) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_ins) begin
          if (cur_last)         state_d = ST_IDLE;
          else if (!fifo_empty) state_d = ST_LOAD;
          else                  state_d = ST_IDLE;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  // State register, registered strobes, issued instruction and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ready_en    <= 1'b0;
      command_in  <= '0;
      command_we0 <= 1'b0;
      command_we1 <= 1'b0;
      cur_last    <= 1'b0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else if (clear) begin
      state_q     <= ST_IDLE;
      ready_en    <= 1'b1;
      command_in  <= '0;
      command_we0 <= 1'b0;
      command_we1 <= 1'b0;
      cur_last    <= 1'b0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q                    <= state_d;
      ready_en                   <= 1'b1;
      {command_we1, command_we0} <= strobe_for(state_d);
      if (state_d == ST_LOAD) begin
        command_in <= head[CMD_W-1:0];
        cur_last   <= head[CMD_W];
      end
      if (finish_ok)  all_done    <= 1'b1;
      if (finish_err) timeout_err <= 1'b1;
    end
  end

  // Watchdog restarts in START and counts every WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wd_q <= '0;
    else if (clear || state_q == ST_START) wd_q <= '0;
    else if (state_q == ST_WAIT)          wd_q <= wd_q + TIMEOUT_W'(1);
  end

  // Program cycle counter: armed by the first LOAD, frozen at completion or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counting    <= 1'b0;
      cycle_count <= '0;
    end else if (clear) begin
      counting    <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (counting && cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_W'(1);
      if (finish_ok || finish_err)            counting <= 1'b0;
      else if (state_d == ST_LOAD)            counting <= 1'b1;
    end
  end

endmodule
